// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle CPU controller: opcodes,
// extended ops, condition codes, state encoding and flag bit indices.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXEC    = 2'd2,
        S_LOAD_WB = 2'd3
    } state_t;

    // Logical immediates are zero-extended; arithmetic ones sign-extended.
    function automatic logic is_zext(input logic [3:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Branch condition evaluation against the registered flags {C,L,F,Z,N}.
module cond_check
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);

    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        take = 1'b0;
        unique case (cond)
            CC_EQ: take = z;
            CC_NE: take = !z;
            CC_CS: take = c;
            CC_CC: take = !c;
            CC_HI: take = l;
            CC_LS: take = !l;
            CC_GT: take = n;
            CC_LE: take = !n;
            CC_FS: take = f;
            CC_FC: take = !f;
            CC_LO: take = !l && !z;
            CC_HS: take = l || z;
            CC_LT: take = !n && !z;
            CC_GE: take = n || z;
            CC_UC: take = 1'b1;
            CC_NV: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
// Optional JAL support (with link_sel output) under CTRL_JAL_EN.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [4:0]        flags,
    output logic [NREGS-1:0]  reg_en,
    output logic [3:0]        mux_a_sel,
    output logic [3:0]        mux_b_sel,
    output logic              imm_sel,
    output logic [DATA_W-1:0] imm_val,
    output logic [15:0]       alu_ctrl,
    output logic              flag_en,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              addr_sel,
    output logic              ld_sel,
    output logic              mem_we,
`ifdef CTRL_JAL_EN
    output logic              link_sel,
`endif
    output logic [1:0]        state_dbg
);

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;
    logic [3:0]        op, rd, ext, rs;
    logic              take;
    logic              is_reg, is_imm, is_lui;
    logic              is_load, is_stor, is_jcond;
    logic [DATA_W-1:0] imm_ext;

    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign ext = ir[7:4];
    assign rs  = ir[3:0];

    assign is_reg   = (op == OP_RTYPE) || (op == OP_SHIFT);
    assign is_imm   = op inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
                                 OP_ADDUI, OP_ADDCI, OP_SUBI,
                                 OP_CMPI, OP_MOVI};
    assign is_lui   = (op == OP_LUI);
    assign is_load  = (op == OP_MEM) && (ext == EXT_LOAD);
    assign is_stor  = (op == OP_MEM) && (ext == EXT_STOR);
    assign is_jcond = (op == OP_MEM) && (ext == EXT_JCOND);

`ifdef CTRL_JAL_EN
    logic is_jal;
    assign is_jal = (op == OP_MEM) && (ext == EXT_JAL);
`endif

    assign imm_ext = is_zext(op)
                   ? {{(DATA_W-8){1'b0}}, ir[7:0]}
                   : {{(DATA_W-8){ir[7]}}, ir[7:0]};

    assign state_dbg = state;

    cond_check u_cond (
        .cond  (rd),
        .flags (flags),
        .take  (take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                ir <= mem_q;
        end
    end

    always_comb begin
        state_next = state;
        reg_en     = '0;
        mux_a_sel  = '0;
        mux_b_sel  = '0;
        imm_sel    = 1'b0;
        imm_val    = '0;
        alu_ctrl   = '0;
        flag_en    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        addr_sel   = 1'b0;
        ld_sel     = 1'b0;
        mem_we     = 1'b0;
`ifdef CTRL_JAL_EN
        link_sel   = 1'b0;
`endif
        unique case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                alu_ctrl   = {op, 4'b0000, ext, 4'b0000};
                unique case (1'b1)
                    is_reg: begin
                        mux_a_sel  = rd;
                        mux_b_sel  = rs;
                        reg_en[rd] = 1'b1;
                        flag_en    = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    is_imm: begin
                        mux_a_sel  = rd;
                        imm_sel    = 1'b1;
                        imm_val    = imm_ext;
                        reg_en[rd] = 1'b1;
                        flag_en    = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    is_lui: begin
                        imm_sel    = 1'b1;
                        imm_val    = {ir[7:0], {(DATA_W-8){1'b0}}};
                        reg_en[rd] = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    is_load: begin
                        mux_a_sel  = rs;
                        addr_sel   = 1'b1;
                        state_next = S_LOAD_WB;
                    end
                    is_stor: begin
                        mux_a_sel = rs;
                        mux_b_sel = rd;
                        addr_sel  = 1'b1;
                        mem_we    = 1'b1;
                        pc_inc    = 1'b1;
                    end
                    is_jcond: begin
                        mux_a_sel = rs;
                        pc_load   = take;
                        pc_inc    = !take;
                    end
`ifdef CTRL_JAL_EN
                    // Link register is written from PC+1 while PC jumps.
                    is_jal: begin
                        mux_a_sel  = rs;
                        pc_load    = 1'b1;
                        reg_en[rd] = 1'b1;
                        link_sel   = 1'b1;
                    end
`endif
                    default: pc_inc = 1'b1;
                endcase
            end
            S_LOAD_WB: begin
                state_next = S_FETCH;
                ld_sel     = 1'b1;
                reg_en[rd] = 1'b1;
                pc_inc     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed table-driven bench for cpu_control_fsm (default build).
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_q;
    logic [4:0]  flags;
    logic [15:0] reg_en;
    logic [3:0]  mux_a_sel, mux_b_sel;
    logic        imm_sel;
    logic [15:0] imm_val;
    logic [15:0] alu_ctrl;
    logic        flag_en, pc_inc, pc_load;
    logic        addr_sel, ld_sel, mem_we;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .mem_q     (mem_q),
        .flags     (flags),
        .reg_en    (reg_en),
        .mux_a_sel (mux_a_sel),
        .mux_b_sel (mux_b_sel),
        .imm_sel   (imm_sel),
        .imm_val   (imm_val),
        .alu_ctrl  (alu_ctrl),
        .flag_en   (flag_en),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .addr_sel  (addr_sel),
        .ld_sel    (ld_sel),
        .mem_we    (mem_we),
        .state_dbg (state_dbg)
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [15:0] reg_en;
        logic [3:0]  mux_a;
        logic [3:0]  mux_b;
        logic        imm_sel;
        logic [15:0] imm_val;
        logic [15:0] alu_ctrl;
        logic        flag_en;
        logic        pc_inc;
        logic        pc_load;
        logic        addr_sel;
        logic        mem_we;
        logic        is_load;
        logic [15:0] wb_reg_en;
    } vec_t;

    function automatic logic [63:0] obs();
        return {2'b00, reg_en, mux_a_sel, mux_b_sel, imm_sel, imm_val,
                alu_ctrl, flag_en, pc_inc, pc_load, addr_sel,
                ld_sel, mem_we};
    endfunction

    function automatic logic [63:0] exp_exec(input vec_t v);
        return {2'b00, v.reg_en, v.mux_a, v.mux_b, v.imm_sel, v.imm_val,
                v.alu_ctrl, v.flag_en, v.pc_inc, v.pc_load, v.addr_sel,
                1'b0, v.mem_we};
    endfunction

    function automatic logic [63:0] exp_wb(input vec_t v);
        return {2'b00, v.wb_reg_en, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction

    function automatic logic cond_ref(input logic [3:0] c,
                                      input logic [4:0] fl);
        logic cf, lf, ff, zf, nf;
        cf = fl[4]; lf = fl[3]; ff = fl[2]; zf = fl[1]; nf = fl[0];
        case (c)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return lf;
            4'd5:  return !lf;
            4'd6:  return nf;
            4'd7:  return !nf;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !lf && !zf;
            4'd11: return lf || zf;
            4'd12: return !nf && !zf;
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at the FETCH cycle; leaves at the next FETCH cycle.
    task automatic run_vec(input vec_t v, input string tag);
        mem_q = v.instr;
        flags = v.flags;
        #1;
        chk({tag, " fetch st"}, 64'(state_dbg), 64'd0);
        chk({tag, " fetch out"}, obs(), 64'd0);
        step();
        chk({tag, " decode st"}, 64'(state_dbg), 64'd1);
        chk({tag, " decode out"}, obs(), 64'd0);
        step();
        chk({tag, " exec st"}, 64'(state_dbg), 64'd2);
        chk({tag, " exec out"}, obs(), exp_exec(v));
        step();
        if (v.is_load) begin
            chk({tag, " wb st"}, 64'(state_dbg), 64'd3);
            chk({tag, " wb out"}, obs(), exp_wb(v));
            step();
        end
    endtask

    vec_t tbl[17];
    vec_t v;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h0553, 5'h00, 16'h0020, 4'h5, 4'h3, 1'b0, 16'h0000,
                    16'h0050, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[1]  = '{16'h5A85, 5'h00, 16'h0400, 4'hA, 4'h0, 1'b1, 16'hFF85,
                    16'h5080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[2]  = '{16'h1A85, 5'h00, 16'h0400, 4'hA, 4'h0, 1'b1, 16'h0085,
                    16'h1080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[3]  = '{16'h4207, 5'h00, 16'h0000, 4'h7, 4'h0, 1'b0, 16'h0000,
                    16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0004};
        tbl[4]  = '{16'h4349, 5'h00, 16'h0000, 4'h9, 4'h3, 1'b0, 16'h0000,
                    16'h4040, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
        tbl[5]  = '{16'h40C6, 5'h02, 16'h0000, 4'h6, 4'h0, 1'b0, 16'h0000,
                    16'h40C0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[6]  = '{16'h40C6, 5'h1D, 16'h0000, 4'h6, 4'h0, 1'b0, 16'h0000,
                    16'h40C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[7]  = '{16'hF312, 5'h00, 16'h0008, 4'h0, 4'h0, 1'b1, 16'h1200,
                    16'hF010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[8]  = '{16'h8A1B, 5'h00, 16'h0400, 4'hA, 4'hB, 1'b0, 16'h0000,
                    16'h8010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[9]  = '{16'hE123, 5'h00, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000,
                    16'hE020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[10] = '{16'h4285, 5'h00, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000,
                    16'h4080, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[11] = '{16'h4E2C, 5'h00, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000,
                    16'h4020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[12] = '{16'hB7F0, 5'h00, 16'h0080, 4'h7, 4'h0, 1'b1, 16'hFFF0,
                    16'hB0F0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[13] = '{16'h3470, 5'h00, 16'h0010, 4'h4, 4'h0, 1'b1, 16'h0070,
                    16'h3070, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[14] = '{16'h4EC3, 5'h00, 16'h0000, 4'h3, 4'h0, 1'b0, 16'h0000,
                    16'h40C0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[15] = '{16'h4FC3, 5'h1F, 16'h0000, 4'h3, 4'h0, 1'b0, 16'h0000,
                    16'h40C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[16] = '{16'h9C80, 5'h00, 16'h1000, 4'hC, 4'h0, 1'b1, 16'hFF80,
                    16'h9080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};

        reset = 1'b1;
        mem_q = 16'h0553;
        flags = 5'h00;
        step();
        step();
        chk("reset st", 64'(state_dbg), 64'd0);
        chk("reset out", obs(), 64'd0);
        reset = 1'b0;

        foreach (tbl[i])
            run_vec(tbl[i], $sformatf("v%0d", i));

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                logic t;
                t = cond_ref(4'(c), 5'(f));
                v = '{{4'h4, 4'(c), 4'hC, 4'h5}, 5'(f), 16'h0, 4'h5, 4'h0,
                      1'b0, 16'h0, 16'h40C0, 1'b0, !t, t, 1'b0, 1'b0,
                      1'b0, 16'h0};
                run_vec(v, $sformatf("cc%0d f%02h", c, f));
            end
        end

        // Reset during LOAD_WB must suppress the write-back.
        mem_q = 16'h4207;
        flags = 5'h00;
        step();
        step();
        step();
        chk("abort ld st", 64'(state_dbg), 64'd3);
        reset = 1'b1;
        step();
        chk("abort ld st0", 64'(state_dbg), 64'd0);
        chk("abort ld out", obs(), 64'd0);
        reset = 1'b0;
        run_vec(tbl[0], "after ld abort");

        // Reset during store EXEC must leave no mem_we afterwards.
        mem_q = 16'h4349;
        step();
        step();
        chk("abort st we", 64'(mem_we), 64'd1);
        reset = 1'b1;
        step();
        chk("abort st st0", 64'(state_dbg), 64'd0);
        chk("abort st out", obs(), 64'd0);
        reset = 1'b0;
        run_vec(tbl[1], "after st abort");
        run_vec(tbl[3], "load again");
        #1;
        chk("final st", 64'(state_dbg), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle instruction controller for the 16-bit CPU. It fetches instruction words from the dual-port memory (port A), decodes them, and drives every control input of the datapath, program counter, PC/address mux, load mux and memory write enable. It replaces the hard-wired control sequence in the CPU top level and sits between memory port A and the datapath.

## Interface
Parameters:
- DATA_W, 16, instruction/data word width (fixed at 16; kept as a parameter for readability only)
- NREGS, 16, register count; `reg_en` is one-hot over NREGS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_q  in  16  memory port A read data; valid one cycle after address
- flags  in  5  registered flags {C,L,F,Z,N}
- reg_en  out  16  one-hot register write enable
- mux_a_sel  out  4  datapath mux A select (Rdest / Raddr / Rtarget)
- mux_b_sel  out  4  datapath mux B select (Rsrc)
- imm_sel  out  1  1 = ALU operand B comes from `imm_val`
- imm_val  out  16  extended immediate
- alu_ctrl  out  16  {ir[15:12],4'b0,ir[7:4],4'b0}; ADD gives 0x0050
- flag_en  out  1  flag register write
- pc_inc  out  1  PC += 1
- pc_load  out  1  PC <= mux A bus
- addr_sel  out  1  memory address: 0 = PC, 1 = mux A bus
- ld_sel  out  1  write-back bus: 0 = ALU, 1 = mem_q
- mem_we  out  1  memory port A write enable
- state_dbg  out  2  current state, for the 7-segment debug display

## Operation
- States: FETCH(0), DECODE(1), EXEC(2), LOAD_WB(3).
- FETCH: addr_sel=0; all other outputs 0. Next: DECODE.
- DECODE: ir <= mem_q; all outputs 0. Next: EXEC.
- EXEC decodes `ir`:
  - Register ALU (op 0000, op 1000): mux_a=ir[11:8], mux_b=ir[3:0], reg_en bit ir[11:8], flag_en=1, pc_inc=1.
  - Immediate ALU (op 0001,0010,0011,0101,0110,0111,1001,1011,1101): mux_a=ir[11:8], imm_sel=1, reg_en bit ir[11:8], flag_en=1, pc_inc=1. imm_val is zero-extended ir[7:0] for 0001/0010/0011 and sign-extended for all other ops.
  - LUI (op 1111): imm_val={ir[7:0],8'h00}, imm_sel=1, reg_en bit ir[11:8], flag_en=0, pc_inc=1.
  - LOAD (0100 d 0000 a): mux_a=a, addr_sel=1. Next: LOAD_WB.
  - STOR (0100 s 0100 a): mux_a=a, mux_b=s, addr_sel=1, mem_we=1, pc_inc=1.
  - Jcond (0100 c 1100 t): mux_a=t. If the condition holds, pc_load=1; otherwise pc_inc=1.
  - All other encodings are a NOP: pc_inc=1 only.
  - Next state after EXEC is FETCH, except LOAD.
- LOAD_WB: ld_sel=1, reg_en bit d, pc_inc=1. Next: FETCH.
- Condition codes:
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - HI 0100 L; LS 0101 !L
  - GT 0110 N; LE 0111 !N
  - FS 1000 F; FC 1001 !F
  - LO 1010 !L&!Z; HS 1011 L|Z
  - LT 1100 !N&!Z; GE 1101 N|Z
  - UC 1110 1; 1111 never.
- pc_inc and pc_load are mutually exclusive. At most one reg_en bit is set.

## Timing
- Outputs are decoded combinationally from state and `ir`; `ir` and state are registered.
- Latency: ALU, immediate, store, jump and NOP take 3 cycles. LOAD takes 4 cycles.
- Reset: state=FETCH, ir=0x0000. In the cycle after reset is sampled, all outputs are 0 and state_dbg=0.
- Reset asserted in any state, including LOAD_WB or during a store, aborts the instruction. No reg_en, mem_we or pc_* pulse occurs in the following cycle.
- `flags` is sampled in EXEC only. A flag write in the preceding instruction's EXEC is already visible.

## Configuration
- CTRL_JAL_EN defined: adds JAL (0100 l 1000 t).
  - EXEC: mux_a=t, pc_load=1, reg_en bit l, and new output link_sel=1 so the write-back bus carries PC+1.
  - 3 cycles total.
- CTRL_JAL_EN undefined: JAL decodes as a NOP, and link_sel is absent.

## Structure
- Package `cpu_ctrl_pkg`: opcode constants, extended-op constants, condition-code constants, state encoding, and flag bit indices.
- One sub-module, `cond_check`: combinational; inputs cond[3:0] and flags[4:0]; output `take`.

## Test plan
- Reset, then mem_q=0x0553 (ADD r5,r3): in EXEC, reg_en=0x0020, mux_a=5, mux_b=3, alu_ctrl=0x0050, flag_en=1, pc_inc=1; FETCH again 3 cycles after the previous FETCH.
- mem_q=0x5A85 (ADDI r10,0x85) → imm_sel=1, imm_val=0xFF85, reg_en=0x0400. Then mem_q=0x1A85 (op 0001) → imm_val=0x0085.
- mem_q=0x4207 (LOAD r2,[r7]) → EXEC: addr_sel=1, mux_a=7, reg_en=0. LOAD_WB: ld_sel=1, reg_en=0x0004, pc_inc=1. Total 4 cycles.
- mem_q=0x4349 (STOR r3,[r9]) → a single-cycle mem_we=1 with mux_a=9, mux_b=3, addr_sel=1; reg_en=0 throughout.
- mem_q=0x40C6 (JEQ r6): with flags Z=1 → pc_load=1, pc_inc=0, mux_a=6; with Z=0 → pc_inc=1, pc_load=0. Repeat for every condition code against every flag pattern.
- Reset asserted in LOAD_WB of 0x4207 → next cycle: state_dbg=0, reg_en=0, pc_inc=0; the normal fetch sequence resumes after reset is released.
